// File: rtl/alu_rr_scheduler.sv
// Two-requester front end for a shared ADD/OR/SUB/XOR datapath: round-robin grant,
// operand capture, a single execute cycle and a result register held until it is consumed.
module alu_rr_scheduler #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [1:0]   op0,
   input  logic [N-1:0] a0,
   input  logic [N-1:0] b0,
   input  logic         req1,
   input  logic [1:0]   op1,
   input  logic [N-1:0] a1,
   input  logic [N-1:0] b1,
   output logic         gnt0,
   output logic         gnt1,
   output logic [N-1:0] res_data,
   output logic         res_id,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   logic [1:0]   state_reg;
   logic [1:0]   state_next;
   logic         rr_ptr_reg;
   logic [1:0]   op_reg;
   logic [N-1:0] a_reg;
   logic [N-1:0] b_reg;
   logic         id_reg;
   logic [N-1:0] res_data_reg;
   logic         res_id_reg;
   logic         res_valid_reg;

   // Requester ports folded into indexed arrays so capture is a simple mux on sel.
   logic [1:0]   req_vec;
   logic [1:0]   gnt_vec;
   logic [1:0]   op_arr [2];
   logic [N-1:0] a_arr  [2];
   logic [N-1:0] b_arr  [2];

   assign req_vec  = {req1, req0};
   assign op_arr[0] = op0;
   assign op_arr[1] = op1;
   assign a_arr[0]  = a0;
   assign a_arr[1]  = a1;
   assign b_arr[0]  = b0;
   assign b_arr[1]  = b1;

   logic sel;
   logic grant_any;

   // Pointer only matters on contention; a lone requester always wins.
   assign sel       = (req_vec == 2'b11) ? rr_ptr_reg : req_vec[1];
   assign grant_any = (state_reg == ST_IDLE) && (|req_vec) && !rst;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
         assign gnt_vec[gi] = grant_any && (sel == 1'(gi));
      end
   endgenerate

   assign gnt0 = gnt_vec[0];
   assign gnt1 = gnt_vec[1];

   logic [N-1:0] alu_result;

   always_comb begin
      alu_result = '0;
      case (op_reg)
         OP_ADD:  alu_result = a_reg + b_reg;
         OP_OR:   alu_result = a_reg | b_reg;
         OP_SUB:  alu_result = a_reg - b_reg;
         OP_XOR:  alu_result = a_reg ^ b_reg;
         default: alu_result = '0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (grant_any) state_next = ST_EXEC;
         ST_EXEC: state_next = ST_OUT;
         ST_OUT:  if (res_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         rr_ptr_reg    <= 1'b0;
         op_reg        <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         id_reg        <= 1'b0;
         res_data_reg  <= '0;
         res_id_reg    <= 1'b0;
         res_valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ST_IDLE: begin
               if (grant_any) begin
                  op_reg <= op_arr[sel];
                  a_reg  <= a_arr[sel];
                  b_reg  <= b_arr[sel];
                  id_reg <= sel;
               end
            end
            ST_EXEC: begin
               res_data_reg  <= alu_result;
               res_id_reg    <= id_reg;
               res_valid_reg <= 1'b1;
            end
            ST_OUT: begin
               // res_data is deliberately left holding the consumed value.
               if (res_ready) begin
                  res_valid_reg <= 1'b0;
                  rr_ptr_reg    <= ~res_id_reg;
               end
            end
            default: res_valid_reg <= 1'b0;
         endcase
      end
   end

   assign res_data  = res_data_reg;
   assign res_id    = res_id_reg;
   assign res_valid = res_valid_reg;
   assign busy      = (state_reg != ST_IDLE);

endmodule
